// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// ALU operation codes, condition codes and the control-word layout.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_EOR = 3'b100
    } alu_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Instruction class (Op field)
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing command field Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Registered control word driven onto the datapath
    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       reg_write;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } ctrl_t;

    // FETCH outputs: PC+4 through the ALU, written back to PC directly
    localparam ctrl_t CTRL_FETCH = '{
        pc_write:    1'b1,
        mem_write:   1'b0,
        reg_write:   1'b0,
        ir_write:    1'b1,
        adr_src:     1'b0,
        alu_src_a:   2'b01,
        alu_src_b:   2'b10,
        result_src:  2'b10,
        alu_control: 3'b000
    };

    // Map a data-processing command onto an ALU operation; CMP is a SUB
    function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
        logic [2:0] alu;
        case (cmd)
            CMD_ADD: alu = ALU_ADD;
            CMD_SUB: alu = ALU_SUB;
            CMD_AND: alu = ALU_AND;
            CMD_ORR: alu = ALU_ORR;
            CMD_EOR: alu = ALU_EOR;
            CMD_CMP: alu = ALU_SUB;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/cond_logic.sv
// Condition-flag register, condition evaluation and the per-instruction
// CondExReg. The condition is judged once in DECODE against the flags as
// they stood then, so an instruction's own flag update cannot change it.
module cond_logic
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cond_capture,
    input  logic       flag_load,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [2:0] alu_control,
    output logic       cond_ex_d,
    output logic       cond_ex_q
);

    logic [3:0] flags_d;
    logic [3:0] flags_q;
    logic       cond_met_s;
    logic       n_s;
    logic       z_s;
    logic       c_s;
    logic       v_s;

    assign {n_s, z_s, c_s, v_s} = flags_q;

    // Evaluate the condition field against the stored flags
    always_comb begin
        cond_met_s = 1'b0;
        case (cond)
            COND_EQ: cond_met_s = z_s;
            COND_NE: cond_met_s = ~z_s;
            COND_CS: cond_met_s = c_s;
            COND_CC: cond_met_s = ~c_s;
            COND_MI: cond_met_s = n_s;
            COND_PL: cond_met_s = ~n_s;
            COND_VS: cond_met_s = v_s;
            COND_VC: cond_met_s = ~v_s;
            COND_HI: cond_met_s = c_s & ~z_s;
            COND_LS: cond_met_s = ~(c_s & ~z_s);
            COND_GE: cond_met_s = (n_s == v_s);
            COND_LT: cond_met_s = (n_s != v_s);
            COND_GT: cond_met_s = ~z_s & (n_s == v_s);
            COND_LE: cond_met_s = ~(~z_s & (n_s == v_s));
            COND_AL: cond_met_s = 1'b1;
            default: cond_met_s = 1'b0;
        endcase
    end

    // Next flags: N,Z always on a load; C,V only for ADD/SUB-class ops
    always_comb begin
        flags_d = flags_q;
        if (flag_load) begin
            flags_d[3:2] = alu_flags[3:2];
            if (alu_control[2:1] == 2'b00) begin
                flags_d[1:0] = alu_flags[1:0];
            end else begin
                flags_d[1:0] = flags_q[1:0];
            end
        end else begin
            flags_d = flags_q;
        end
    end

    // CondExReg samples the verdict only while leaving DECODE
    always_comb begin
        if (cond_capture) begin
            cond_ex_d = cond_met_s;
        end else begin
            cond_ex_d = cond_ex_q;
        end
    end

    // Flag and condition registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle controller: Moore FSM sequencing fetch/decode/execute, with the
// datapath control word registered alongside the state so every output is
// glitch-free for the whole state. ImmSrc/RegSrc follow Op combinationally.
module mc_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUControl
);

    logic [3:0] cond_s;
    logic [1:0] op_s;
    logic [5:0] funct_s;
    logic [3:0] rd_s;
    logic [3:0] unused_rn_s;

    state_e     state_d;
    state_e     state_q;
    ctrl_t      ctrl_d;
    ctrl_t      ctrl_q;
    logic       reg_w_s;
    logic       mem_w_s;
    logic       branch_s;
    logic       cond_capture_s;
    logic       flag_load_s;
    logic       cond_ex_d_s;
    logic       cond_ex_q_s;

    // Instr carries IR[31:12]; Rn (IR[19:16]) is not needed here
    assign cond_s      = Instr[19:16];
    assign op_s        = Instr[15:14];
    assign funct_s     = Instr[13:8];
    assign unused_rn_s = Instr[7:4];
    assign rd_s        = Instr[3:0];

    assign cond_capture_s = (state_q == S_DECODE);
    assign flag_load_s    = ((state_q == S_EXECR) || (state_q == S_EXECI))
                            && cond_ex_q_s && funct_s[0];

    cond_logic u_cond (
        .clk          (clk),
        .reset        (reset),
        .cond_capture (cond_capture_s),
        .flag_load    (flag_load_s),
        .cond         (cond_s),
        .alu_flags    (ALUFlags),
        .alu_control  (ctrl_q.alu_control),
        .cond_ex_d    (cond_ex_d_s),
        .cond_ex_q    (cond_ex_q_s)
    );

    // Next-state sequencing of the instruction flow
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op_s)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct_s[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = funct_s[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control word for the state being entered, gated by the condition
    always_comb begin
        ctrl_d   = '0;
        reg_w_s  = 1'b0;
        mem_w_s  = 1'b0;
        branch_s = 1'b0;
        case (state_d)
            S_FETCH: ctrl_d = CTRL_FETCH;
            S_DECODE: begin
                ctrl_d.alu_src_a   = 2'b01;
                ctrl_d.alu_src_b   = 2'b10;
                ctrl_d.result_src  = 2'b10;
                ctrl_d.alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl_d.alu_src_a   = 2'b00;
                ctrl_d.alu_src_b   = 2'b01;
                ctrl_d.alu_control = funct_s[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD: begin
                ctrl_d.adr_src    = 1'b1;
                ctrl_d.result_src = 2'b00;
            end
            S_MEMWB: begin
                ctrl_d.result_src = 2'b01;
                reg_w_s           = 1'b1;
            end
            S_MEMWR: begin
                ctrl_d.adr_src = 1'b1;
                mem_w_s        = 1'b1;
            end
            S_EXECR: begin
                ctrl_d.alu_src_a   = 2'b00;
                ctrl_d.alu_src_b   = 2'b00;
                ctrl_d.alu_control = alu_decode(funct_s[4:1]);
            end
            S_EXECI: begin
                ctrl_d.alu_src_a   = 2'b00;
                ctrl_d.alu_src_b   = 2'b01;
                ctrl_d.alu_control = alu_decode(funct_s[4:1]);
            end
            S_ALUWB: begin
                ctrl_d.result_src = 2'b00;
                reg_w_s           = (funct_s[4:1] != CMD_CMP);
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a   = 2'b00;
                ctrl_d.alu_src_b   = 2'b01;
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.result_src  = 2'b10;
                branch_s           = 1'b1;
            end
            default: ctrl_d = CTRL_FETCH;
        endcase
        // A write to R15 through the register path is also a PC write
        ctrl_d.reg_write = reg_w_s & cond_ex_d_s;
        ctrl_d.mem_write = mem_w_s & cond_ex_d_s;
        ctrl_d.pc_write  = (state_d == S_FETCH)
                           | (cond_ex_d_s & (branch_s | (reg_w_s & (rd_s == 4'hF))));
    end

    // State and registered control word; reset lands in FETCH
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= CTRL_FETCH;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign PCWrite    = ctrl_q.pc_write;
    assign MemWrite   = ctrl_q.mem_write;
    assign RegWrite   = ctrl_q.reg_write;
    assign IRWrite    = ctrl_q.ir_write;
    assign AdrSrc     = ctrl_q.adr_src;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign ResultSrc  = ctrl_q.result_src;
    assign ALUControl = ctrl_q.alu_control;

    assign ImmSrc = op_s;
    assign RegSrc = {(op_s == OP_MEM), (op_s == OP_BR)};

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus pushes the hand-derived output
// word of each cycle; a negedge monitor pops and compares.
module tb_mc_control;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;

    typedef struct {
        string       nm;
        logic [17:0] outs;
        logic        chk_flags;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    logic [1:0] cur_op;

    mc_control dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word: {PCW,MemW,RegW,IRW,AdrSrc,SrcA,SrcB,ResSrc,ImmSrc,RegSrc,ALUCtl}
    function automatic logic [17:0] v(input logic pcw, input logic mw, input logic rw,
                                      input logic irw, input logic adr,
                                      input logic [1:0] asa, input logic [1:0] asb,
                                      input logic [1:0] rs, input logic [2:0] alu);
        return {pcw, mw, rw, irw, adr, asa, asb, rs, cur_op,
                {(cur_op == 2'b01), (cur_op == 2'b10)}, alu};
    endfunction

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] f, input logic [3:0] rd);
        return {c, op, f, 4'h0, rd};
    endfunction

    task automatic cyc(input string nm, input logic [17:0] e, input logic [3:0] af,
                       input logic chk, input logic [3:0] ef);
        exp_t x;
        x.nm = nm; x.outs = e; x.chk_flags = chk; x.flags = ef;
        ALUFlags = af;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [19:0] ins);
        Instr  = ins;
        cur_op = ins[15:14];
        cyc("fetch",  v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b01,2'b10,2'b10,3'b000), 4'h0, 1'b0, 4'h0);
        cyc("decode", v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b10,3'b000), 4'h0, 1'b0, 4'h0);
    endtask

    task automatic dp(input logic [19:0] ins, input logic imm, input logic [2:0] alu,
                      input logic [3:0] af, input logic wb_pcw, input logic wb_rw,
                      input logic chk, input logic [3:0] ef);
        fetch_decode(ins);
        cyc("exec",  v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,(imm ? 2'b01 : 2'b00),2'b00,alu), af, 1'b0, 4'h0);
        cyc("aluwb", v(wb_pcw,1'b0,wb_rw,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000), 4'h0, chk, ef);
    endtask

    task automatic br(input logic [19:0] ins, input logic pcw);
        fetch_decode(ins);
        cyc("branch", v(pcw,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,3'b000), 4'h0, 1'b0, 4'h0);
    endtask

    task automatic memadr(input logic [2:0] alu);
        cyc("memadr", v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,alu), 4'h0, 1'b0, 4'h0);
    endtask

    // Monitor: compare every cycle the stimulus has an expectation for
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [17:0] got;
            e   = sb.pop_front();
            got = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
                   ResultSrc, ImmSrc, RegSrc, ALUControl};
            vectors++;
            if (got !== e.outs) begin
                miscompares++;
                $display("FAIL %s @%0t: outputs got %b want %b", e.nm, $time, got, e.outs);
            end
            if (e.chk_flags) begin
                vectors++;
                if (dut.u_cond.flags_q !== e.flags) begin
                    miscompares++;
                    $display("FAIL %s_flags @%0t: got %b want %b", e.nm, $time,
                             dut.u_cond.flags_q, e.flags);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b0; Instr = 20'h0; ALUFlags = 4'h0; cur_op = 2'b00;
        @(posedge clk); @(posedge clk); #1;
        // Held in reset: FETCH outputs, flags cleared
        cyc("reset", v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b01,2'b10,2'b10,3'b000), 4'h0, 1'b1, 4'b0000);
        reset = 1'b1;

        // ADDS R1: flags <- 0100
        dp(mk(4'hE,2'b00,6'b001001,4'h1), 1'b0, 3'b000, 4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100);
        // CMP: no write-back, flags <- 0110
        dp(mk(4'hE,2'b00,6'b010101,4'h0), 1'b0, 3'b001, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0110);
        // BEQ taken, BNE not taken
        br(mk(4'h0,2'b10,6'b000000,4'h0), 1'b1);
        br(mk(4'h1,2'b10,6'b000000,4'h0), 1'b0);

        // LDR (U=1 -> ADD)
        fetch_decode(mk(4'hE,2'b01,6'b011001,4'h2));
        memadr(3'b000);
        cyc("memrd", v(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b000), 4'h0, 1'b0, 4'h0);
        cyc("memwb", v(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b01,3'b000), 4'h0, 1'b0, 4'h0);
        // STR (U=0 -> SUB)
        fetch_decode(mk(4'hE,2'b01,6'b010000,4'h2));
        memadr(3'b001);
        cyc("memwr", v(1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b000), 4'h0, 1'b0, 4'h0);

        // ADDSNE with Z=1: suppressed, flags keep 0110 despite ALUFlags=1111
        dp(mk(4'h1,2'b00,6'b001001,4'h1), 1'b0, 3'b000, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0110);
        // ADDS: flags <- 0011
        dp(mk(4'hE,2'b00,6'b001001,4'h1), 1'b0, 3'b000, 4'b0011, 1'b0, 1'b1, 1'b1, 4'b0011);
        // ANDS: N,Z load, C,V hold 11 -> 1011
        dp(mk(4'hE,2'b00,6'b000001,4'h4), 1'b0, 3'b010, 4'b1000, 1'b0, 1'b1, 1'b1, 4'b1011);
        // BVS taken, BLT not taken (N==V)
        br(mk(4'h6,2'b10,6'b000000,4'h0), 1'b1);
        br(mk(4'hB,2'b10,6'b000000,4'h0), 1'b0);
        // ORR to R15: PC write plus reg write
        dp(mk(4'hE,2'b00,6'b011000,4'hF), 1'b0, 3'b011, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0);
        // ADDGT immediate, taken
        dp(mk(4'hC,2'b00,6'b101000,4'h3), 1'b1, 3'b000, 4'h0, 1'b0, 1'b1, 1'b1, 4'b1011);
        // Op=11 returns straight to FETCH
        fetch_decode(mk(4'hE,2'b11,6'b000000,4'h0));
        // EOR with condition 1111: never executes
        dp(mk(4'hF,2'b00,6'b000010,4'h5), 1'b0, 3'b100, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);

        // STR interrupted by reset in MEMWR
        fetch_decode(mk(4'hE,2'b01,6'b011000,4'h2));
        memadr(3'b000);
        reset = 1'b0;
        cyc("memwr_rst", v(1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b000), 4'h0, 1'b0, 4'h0);
        cyc("post_rst", v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b01,2'b10,2'b10,3'b000), 4'h0, 1'b1, 4'b0000);
        reset = 1'b1;
        // Flags cleared: BEQ no longer taken
        br(mk(4'h0,2'b10,6'b000000,4'h0), 1'b0);
        fetch_decode(mk(4'hE,2'b11,6'b000000,4'h0));

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 SHALL have ports (name  direction  width  meaning), one per line:
  clk  in  1  single clock, all state on rising edge
  reset  in  1  synchronous, active-low reset
  Instr  in  20  instruction bits [31:12] from IR: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
  ALUFlags  in  4  {N,Z,C,V} from ALU, same cycle as ALUControl
  PCWrite  out  1  PC register enable
  MemWrite  out  1  data memory write enable
  RegWrite  out  1  register file write enable
  IRWrite  out  1  instruction register enable
  AdrSrc  out  1  memory address: 0=PC, 1=ALU result
  ALUSrcA  out  2  00=register A, 01=PC
  ALUSrcB  out  2  00=register B, 01=extended imm, 10=constant 4
  ResultSrc  out  2  00=ALUOut reg, 01=read data, 10=ALU result direct
  ImmSrc  out  2  extender select, equals Op
  RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
  ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR

Function
REQ-003 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-004 Transitions: FETCH->DECODE; DECODE: Op=01->MEMADR, Op=00&Funct[5]=0->EXECR, Op=00&Funct[5]=1->EXECI, Op=10->BRANCH, Op=11->FETCH; MEMADR: Funct[0]=1->MEMRD else MEMWR; MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-005 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1 unconditionally.
REQ-006 DECODE: ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=10; no write enables.
REQ-007 MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=000 (ADD), or 001 (SUB) when Funct[3]=0 (U bit clear).
REQ-008 MEMRD: AdrSrc=1, ResultSrc=00; MEMWB: ResultSrc=01, RegW; MEMWR: AdrSrc=1, MemW.
REQ-009 EXECR: ALUSrcA=00, ALUSrcB=00; EXECI: ALUSrcA=00, ALUSrcB=01; both decode ALUControl from Funct[4:1]: 0100->000, 0010->001, 0000->010, 1100->011, 0001->100, 1010 (CMP)->001; any other->000.
REQ-010 ALUWB: ResultSrc=00, RegW unless cmd=CMP; BRANCH: ALUSrcA=00, ALUSrcB=01, ALUControl=000, ResultSrc=10, Branch.
REQ-011 Unlisted outputs SHALL be 0 in each state; ImmSrc and RegSrc SHALL be combinational from Op in all states.
REQ-012 Condition SHALL be evaluated from Cond against the 4-bit flags register: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !(C&!Z), GE N==V, LT N!=V, GT !Z&(N==V), LE !(!Z&(N==V)), AL 1, 1111 -> 0.
REQ-013 CondExReg SHALL capture the condition result on the DECODE->next edge and hold until next DECODE.
REQ-014 RegWrite=RegW&CondExReg; MemWrite=MemW&CondExReg; PCWrite=FETCH | CondExReg&(Branch | RegW&Rd==1111).
REQ-015 Flags register: at end of EXECR/EXECI when CondExReg=1 and Funct[0]=1, N,Z SHALL load from ALUFlags; C,V SHALL load only if ALUControl[2:1]==00; otherwise hold.
REQ-016 Flags written in EXECx SHALL NOT affect CondExReg of the same instruction.

Reset
REQ-017 reset low at a rising edge SHALL force state FETCH, flags 0000, CondExReg 0; next cycle after release emits FETCH outputs.
REQ-018 Reset mid-instruction SHALL abandon it; no write enable asserted in the reset cycle's outputs beyond FETCH values.

Structure
REQ-019 State encoding, ALUControl codes, condition codes SHALL live in shared package mc_pkg.
REQ-020 Flags register, condition evaluation and CondExReg SHALL form sub-module cond_logic.

Verification
REQ-021 ADDS R1 (Cond=1110, Op=00, Funct=001001): FETCH,DECODE,EXECR,ALUWB; ALUControl=000; ALUFlags=0100 -> flags 0100, RegWrite=1 in ALUWB.
REQ-022 CMP then BEQ: ALUFlags=0110 in EXECR (Funct=010101) -> RegWrite=0 in ALUWB; BRANCH with Cond=0000 -> PCWrite=1.
REQ-023 BNE after Z=1 -> BRANCH state PCWrite=0; next FETCH PCWrite=1.
REQ-024 LDR (Op=01, Funct=011001): 5 cycles FETCH..MEMWB, AdrSrc=1 in MEMRD, ResultSrc=01 and RegWrite=1 in MEMWB; STR (Funct[0]=0) -> MEMWR MemWrite=1.
REQ-025 ORR Rd=1111 in ALUWB -> PCWrite=1 and RegWrite=1; ANDS sets N,Z but C,V hold prior 11.
REQ-026 reset low during MEMWR -> MemWrite=0 next cycle, state FETCH, flags 0000.
